// File: rtl/nonce_scan_pkg.sv
// nonce_scan_pkg: shared state encoding and result-record layout for the nonce scanner
package nonce_scan_pkg;

    typedef enum logic [2:0] {IDLE, READ, DRAIN, WRITE0, WRITE1, FINISH} state_e;

    localparam int FOUND_BIT     = 31;
    localparam int COUNT_LSB     = 16;
    localparam int NONCE_LSB     = 0;
    localparam int COUNT_FIELD_W = 5;
    localparam int NONCE_FIELD_W = 16;
    localparam int RESULT_WORDS  = 2;

    function automatic logic [31:0] summary_word(input logic f,
                                                 input logic [COUNT_FIELD_W-1:0] c,
                                                 input logic [NONCE_FIELD_W-1:0] n);
        logic [31:0] s;
        s = '0;
        s[FOUND_BIT] = f;
        s[COUNT_LSB +: COUNT_FIELD_W] = c;
        s[NONCE_LSB +: NONCE_FIELD_W] = n;
        return s;
    endfunction

endpackage

// File: rtl/mem_read_pipe.sv
// mem_read_pipe: sequential read address generator with a 2-stage valid/index pipe
// matching the two-cycle latency from registered address to usable read data.
module mem_read_pipe #(
    parameter int NUM_NONCES = 16,
    parameter int NONCE_W    = $clog2(NUM_NONCES)
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               clear_i,
    input  logic               issue_i,
    input  logic [15:0]        base_i,
    input  logic [31:0]        rdata_i,
    output logic [15:0]        addr_o,
    output logic               last_o,
    output logic               data_valid_o,
    output logic [NONCE_W-1:0] data_index_o,
    output logic [31:0]        data_o
);

    logic [NONCE_W-1:0] idx_q, ix0_q, ix1_q;
    logic [1:0]         vld_q;

    assign addr_o       = base_i + 16'(idx_q);
    assign last_o       = idx_q == NONCE_W'(NUM_NONCES - 1);
    assign data_valid_o = vld_q[1];
    assign data_index_o = ix1_q;
    assign data_o       = rdata_i;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            idx_q <= '0;
            ix0_q <= '0;
            ix1_q <= '0;
            vld_q <= '0;
        end else begin
            idx_q <= clear_i ? '0 : issue_i ? idx_q + 1'b1 : idx_q;
            vld_q <= {vld_q[0], issue_i};
            ix0_q <= idx_q;
            ix1_q <= ix0_q;
        end
    end

endmodule

// File: rtl/nonce_result_scanner.sv
// nonce_result_scanner: scans per-nonce hash words, tracks minimum and target matches,
// and writes a two-word result record back through the shared single-port memory.
module nonce_result_scanner
    import nonce_scan_pkg::*;
#(
    parameter int NUM_NONCES = 16,
    parameter int NONCE_W    = $clog2(NUM_NONCES)
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               start,
    input  logic [15:0]        input_addr,
    input  logic [15:0]        result_addr,
    input  logic [31:0]        target,
    output logic               done,
    output logic               found,
    output logic [NONCE_W-1:0] best_nonce,
    output logic [31:0]        best_value,
    output logic [NONCE_W:0]   match_count,
    output logic               mem_clk,
    output logic               mem_we,
    output logic [15:0]        mem_addr,
    output logic [31:0]        mem_write_data,
    input  logic [31:0]        mem_read_data
);

    state_e             state_q;
    logic               done_q, we_q, found_q, found_d;
    logic [15:0]        addr_q, in_base_q, res_base_q, rd_addr;
    logic [31:0]        wdata_q, target_q, value_q, value_d, rd_data;
    logic [NONCE_W-1:0] nonce_q, nonce_d, rd_index;
    logic [NONCE_W:0]   count_q, count_d;
    logic               rd_last, rd_valid, hit, better;

    mem_read_pipe #(.NUM_NONCES(NUM_NONCES), .NONCE_W(NONCE_W)) u_pipe (
        .clk          (clk),
        .reset_n      (reset_n),
        .clear_i      (state_q == IDLE && start),
        .issue_i      (state_q == READ),
        .base_i       (in_base_q),
        .rdata_i      (mem_read_data),
        .addr_o       (rd_addr),
        .last_o       (rd_last),
        .data_valid_o (rd_valid),
        .data_index_o (rd_index),
        .data_o       (rd_data)
    );

    // Strict compares: ties keep the earlier nonce, a word equal to target does not count.
    always_comb begin
        hit     = rd_valid && (rd_data < target_q);
        better  = rd_valid && (rd_data < value_q);
        value_d = better ? rd_data : value_q;
        nonce_d = better ? rd_index : nonce_q;
        count_d = count_q + {{NONCE_W{1'b0}}, hit};
        found_d = found_q | hit;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            done_q     <= 1'b1;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            found_q    <= 1'b0;
            nonce_q    <= '0;
            value_q    <= '1;
            count_q    <= '0;
            in_base_q  <= '0;
            res_base_q <= '0;
            target_q   <= '0;
        end else begin
            found_q <= found_d;
            nonce_q <= nonce_d;
            value_q <= value_d;
            count_q <= count_d;
            case (state_q)
                IDLE: if (start) begin
                    in_base_q  <= input_addr;
                    res_base_q <= result_addr;
                    target_q   <= target;
                    found_q    <= 1'b0;
                    count_q    <= '0;
                    nonce_q    <= '0;
                    value_q    <= '1;
                    done_q     <= 1'b0;
                    state_q    <= READ;
                end
                READ: begin
                    addr_q  <= rd_addr;
                    state_q <= rd_last ? DRAIN : READ;
                end
                DRAIN: state_q <= (rd_valid && rd_index == NONCE_W'(NUM_NONCES - 1)) ? WRITE0 : DRAIN;
                WRITE0: begin
                    we_q    <= 1'b1;
                    addr_q  <= res_base_q;
                    wdata_q <= value_d;
                    state_q <= WRITE1;
                end
                WRITE1: begin
                    addr_q  <= res_base_q + 16'(RESULT_WORDS - 1);
                    wdata_q <= summary_word(found_q, COUNT_FIELD_W'(count_q), NONCE_FIELD_W'(nonce_q));
                    state_q <= FINISH;
                end
                FINISH: begin
                    we_q    <= 1'b0;
                    done_q  <= 1'b1;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign done           = done_q;
    assign found          = found_q;
    assign best_nonce     = nonce_q;
    assign best_value     = value_q;
    assign match_count    = count_q;
    assign mem_clk        = clk;
    assign mem_we         = we_q;
    assign mem_addr       = addr_q;
    assign mem_write_data = wdata_q;

endmodule

// File: tb/tb_nonce_result_scanner.sv
// tb_nonce_result_scanner: directed vector table, reset corner cases and randomized scans
module tb_nonce_result_scanner;

    localparam int N = 16;

    logic        clk = 0, reset_n = 0, start = 0;
    logic [15:0] input_addr = 0, result_addr = 0;
    logic [31:0] target = 0;
    logic        done, found, mem_clk, mem_we;
    logic [3:0]  best_nonce;
    logic [31:0] best_value, mem_write_data, mem_read_data = 0;
    logic [4:0]  match_count;
    logic [15:0] mem_addr;

    logic [31:0] mem [0:65535];
    int checks = 0, errors = 0;
    int lo, wen, wfirst;

    nonce_result_scanner dut (
        .clk(clk), .reset_n(reset_n), .start(start), .input_addr(input_addr),
        .result_addr(result_addr), .target(target), .done(done), .found(found),
        .best_nonce(best_nonce), .best_value(best_value), .match_count(match_count),
        .mem_clk(mem_clk), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_write_data(mem_write_data), .mem_read_data(mem_read_data)
    );

    always #5 clk = ~clk;

    // Synchronous single-port memory: one cycle from address to read data.
    always @(posedge clk) begin
        logic [31:0] r;
        r = mem[mem_addr];
        if (mem_we) mem[mem_addr] = mem_write_data;
        mem_read_data <= r;
    end

    typedef struct {
        int          pat;
        logic [15:0] ib, rb;
        logic [31:0] tg;
        bit          poke;
        logic        f;
        logic [4:0]  cnt;
        logic [3:0]  nonce;
        logic [31:0] val, sum;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] pword(input int p, input int i);
        case (p)
            0: return 32'h10000000 + 32'(i);
            1: return 32'hFFFFFFFF;
            2: return (i == 5 || i == 9) ? 32'h42 : 32'h1000 + 32'(i);
            3: return 32'h500 - 32'(3 * i);
            default: return 32'h0;
        endcase
    endfunction

    task automatic scan(input logic [15:0] ib, input logic [15:0] rb, input logic [31:0] tg, input bit poke);
        int cyc;
        mem[rb] = 32'hDEADBEEF;
        mem[rb + 16'd1] = 32'hDEADBEEF;
        @(negedge clk);
        input_addr = ib; result_addr = rb; target = tg; start = 1;
        @(negedge clk);
        start = 0; lo = 0; wen = 0; wfirst = -1; cyc = 0;
        while (!done && cyc < 200) begin
            lo++;
            if (mem_we) begin
                wen++;
                if (wfirst < 0) wfirst = lo;
            end
            if (poke && lo == 6) begin
                start = 1; input_addr = ~ib; result_addr = ~rb; target = ~tg;
            end
            if (poke && lo == 8) start = 0;
            @(negedge clk);
            cyc++;
        end
        chk("scan_terminates", {31'b0, done}, 32'd1);
        input_addr = ib; result_addr = rb; target = tg;
    endtask

    task automatic check_res(input string tag, input logic [15:0] rb, input logic f, input logic [4:0] cnt,
                             input logic [3:0] nonce, input logic [31:0] val, input logic [31:0] sum);
        chk({tag, ".found"}, {31'b0, found}, {31'b0, f});
        chk({tag, ".match_count"}, {27'b0, match_count}, {27'b0, cnt});
        chk({tag, ".best_nonce"}, {28'b0, best_nonce}, {28'b0, nonce});
        chk({tag, ".best_value"}, best_value, val);
        chk({tag, ".mem_value"}, mem[rb], val);
        chk({tag, ".mem_summary"}, mem[rb + 16'd1], sum);
        chk({tag, ".done_low_cycles"}, 32'(lo), 32'(N + 5));
        chk({tag, ".we_cycles"}, 32'(wen), 32'd2);
        chk({tag, ".we_first"}, 32'(wfirst), 32'(N + 4));
    endtask

    vec_t tbl [6];

    initial begin
        logic [31:0] w [N];
        logic [31:0] mn, sm;
        logic [15:0] ib, rb;
        logic [31:0] tg;
        int cnt, bn;

        tbl[0] = '{0, 16'h0100, 16'h0200, 32'h10000008, 0, 1'b1, 5'd8,  4'd0,  32'h10000000, 32'h80080000};
        tbl[1] = '{1, 16'h0300, 16'h0400, 32'h00000100, 0, 1'b0, 5'd0,  4'd0,  32'hFFFFFFFF, 32'h00000000};
        tbl[2] = '{2, 16'h0500, 16'h0600, 32'h00000042, 1, 1'b0, 5'd0,  4'd5,  32'h00000042, 32'h00000005};
        tbl[3] = '{3, 16'hFFFE, 16'h0700, 32'h000004F0, 0, 1'b1, 5'd10, 4'd15, 32'h000004D3, 32'h800A000F};
        tbl[4] = '{4, 16'h0800, 16'h0900, 32'h00000001, 1, 1'b1, 5'd16, 4'd0,  32'h00000000, 32'h80100000};
        tbl[5] = '{4, 16'h0A00, 16'h0B00, 32'h00000000, 0, 1'b0, 5'd0,  4'd0,  32'h00000000, 32'h00000000};

        repeat (2) @(negedge clk);
        chk("rst.done", {31'b0, done}, 32'd1);
        chk("rst.mem_we", {31'b0, mem_we}, 32'd0);
        chk("rst.mem_addr", {16'b0, mem_addr}, 32'd0);
        chk("rst.mem_write_data", mem_write_data, 32'd0);
        chk("rst.found", {31'b0, found}, 32'd0);
        chk("rst.best_nonce", {28'b0, best_nonce}, 32'd0);
        chk("rst.best_value", best_value, 32'hFFFFFFFF);
        chk("rst.match_count", {27'b0, match_count}, 32'd0);
        reset_n = 1;

        for (int t = 0; t < 6; t++) begin
            for (int i = 0; i < N; i++) mem[tbl[t].ib + 16'(i)] = pword(tbl[t].pat, i);
            scan(tbl[t].ib, tbl[t].rb, tbl[t].tg, tbl[t].poke);
            check_res($sformatf("vec%0d", t), tbl[t].rb, tbl[t].f, tbl[t].cnt, tbl[t].nonce, tbl[t].val, tbl[t].sum);
        end

        // Reset in the middle of a scan must abort without touching the result area.
        for (int i = 0; i < N; i++) mem[16'h0C00 + 16'(i)] = pword(0, i);
        mem[16'h0D00] = 32'hDEADBEEF;
        mem[16'h0D01] = 32'hDEADBEEF;
        @(negedge clk);
        input_addr = 16'h0C00; result_addr = 16'h0D00; target = 32'h10000008; start = 1;
        @(posedge clk);
        #1 start = 0;
        repeat (10) @(posedge clk);
        #2 reset_n = 0;
        #1;
        chk("midrst.mem_we", {31'b0, mem_we}, 32'd0);
        chk("midrst.done", {31'b0, done}, 32'd1);
        chk("midrst.best_value", best_value, 32'hFFFFFFFF);
        chk("midrst.match_count", {27'b0, match_count}, 32'd0);
        chk("midrst.mem_addr", {16'b0, mem_addr}, 32'd0);
        repeat (3) @(negedge clk);
        reset_n = 1;
        repeat (30) @(negedge clk);
        chk("midrst.done_idle", {31'b0, done}, 32'd1);
        chk("midrst.mem_untouched0", mem[16'h0D00], 32'hDEADBEEF);
        chk("midrst.mem_untouched1", mem[16'h0D01], 32'hDEADBEEF);
        scan(16'h0C00, 16'h0D00, 32'h10000008, 0);
        check_res("postrst", 16'h0D00, 1'b1, 5'd8, 4'd0, 32'h10000000, 32'h80080000);

        // Randomized scans against a reference built from min/count over the word list.
        for (int r = 0; r < 20; r++) begin
            int mode;
            mode = $urandom_range(0, 2);
            ib = 16'($urandom);
            rb = ib + 16'h0100;
            tg = (mode == 1) ? $urandom_range(0, 8) : $urandom;
            for (int i = 0; i < N; i++) begin
                w[i] = (mode == 1) ? $urandom_range(0, 7) :
                       (mode == 2 && $urandom_range(0, 1) == 1) ? 32'hFFFFFFFF : $urandom;
                mem[ib + 16'(i)] = w[i];
            end
            mn = 32'hFFFFFFFF;
            cnt = 0;
            foreach (w[i]) begin
                if (w[i] < mn) mn = w[i];
                if (w[i] < tg) cnt++;
            end
            bn = 0;
            if (mn != 32'hFFFFFFFF)
                for (int i = N - 1; i >= 0; i--) if (w[i] == mn) bn = i;
            sm = ((cnt > 0) ? 32'h80000000 : 32'h0) + 32'(cnt) * 32'h10000 + 32'(bn);
            scan(ib, rb, tg, r[0]);
            check_res($sformatf("rnd%0d", r), rb, cnt > 0, 5'(cnt), 4'(bn), mn, sm);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/nonce_result_scanner.md
Name: nonce_result_scanner

Overview:
- Downstream stage of the bitcoin_hash block.
- After bitcoin_hash has written one 32-bit H0 word per nonce to the output area of the shared memory, this block scans those words.
- It compares each word against a 32-bit difficulty target and tracks the minimum word and its nonce.
- It writes a two-word result record back to memory and signals done; it uses the same single-port memory interface as bitcoin_hash.

Parameters:
NUM_NONCES, 16, number of consecutive hash words to scan (nonce i stored at input_addr+i)
NONCE_W, $clog2(NUM_NONCES), width of the nonce index

Ports:
clk  input  1  system clock; also drives mem_clk
reset_n  input  1  asynchronous active-low reset
start  input  1  begin a scan; sampled only in IDLE
input_addr  input  16  base address of the hash words
result_addr  input  16  base address of the 2-word result record
target  input  32  unsigned threshold; a word qualifies if word < target
done  output  1  high while IDLE
found  output  1  at least one word < target in the last scan
best_nonce  output  NONCE_W  index of the minimum word
best_value  output  32  minimum word value
match_count  output  NONCE_W+1  number of words < target
mem_clk  output  1  equal to clk
mem_we  output  1  memory write enable
mem_addr  output  16  memory address (registered)
mem_write_data  output  32  memory write data (registered)
mem_read_data  input  32  memory read data

Behaviour:
- Clock and reset: one clock, clk; reset_n is asynchronous, active-low.
- Reset values: state=IDLE, done=1, mem_we=0, mem_addr=0, mem_write_data=0, found=0, best_nonce=0, best_value=32'hFFFFFFFF, match_count=0.
- Memory timing: mem_addr is registered. Data for an address set at rising edge k is sampled at edge k+2. Reads are fully pipelined, one address per cycle.
- IDLE: done=1, mem_we=0.
  - When start=1 at edge 0: latch input_addr, result_addr and target; clear found, match_count and best_nonce; set best_value=FFFFFFFF; done<=0; enter READ.
- READ: issue addresses input_addr+0 through input_addr+NUM_NONCES-1 on edges 1..NUM_NONCES.
  - A 2-deep valid/index shift pipe pairs each returning word with its index.
  - Word i is sampled at edge i+3.
  - Once all addresses are issued, hold mem_addr and wait in DRAIN until the last word is sampled at edge NUM_NONCES+2.
- Compare, for each sampled word w with index i:
  - If w < target (unsigned, strict), match_count++ and found<=1.
  - If w < best_value (strict), best_value<=w and best_nonce<=i.
  - Ties keep the lower nonce. A word equal to target does not qualify.
  - A word of FFFFFFFF never replaces the initial best, so best_nonce stays 0.
  - The minimum is tracked regardless of the target.
- WRITE0 (edge NUM_NONCES+3): mem_we<=1, mem_addr<=result_addr, mem_write_data<=best_value. The value includes the final word's update, which is forwarded combinationally from the compare.
- WRITE1 (edge NUM_NONCES+4): mem_addr<=result_addr+1, mem_write_data<=summary word:
  - bit31 = found
  - bits 20:16 = match_count (zero-extended/truncated to 5 bits)
  - bits 15:0 = best_nonce (zero-extended)
  - all other bits 0
- FINISH (edge NUM_NONCES+5): mem_we<=0, done<=1, state<=IDLE.
- Total: done is low for exactly NUM_NONCES+5 cycles.
- Outputs found, best_nonce, best_value and match_count update live during the scan and hold their final values in IDLE until the next start.
- start while not IDLE is ignored.
- Address arithmetic is 16-bit and wraps modulo 2^16 (e.g. input_addr=16'hFFFF reads FFFF then 0000...).
- reset_n low mid-scan: immediate return to reset values, mem_we drops asynchronously, and no further writes occur.
- mem_we is never high during READ/DRAIN.

Decomposition:
- Package nonce_scan_pkg:
  - state enum {IDLE, READ, DRAIN, WRITE0, WRITE1, FINISH}
  - summary-word bit-position constants (FOUND_BIT=31, COUNT_LSB=16, NONCE_LSB=0)
  - RESULT_WORDS=2
- Sub-module mem_read_pipe:
  - issues sequential addresses
  - carries a valid bit and index through a 2-stage shift register aligned to the memory latency
  - outputs data_valid, data_index and data.

Test Plan:
- All 16 words = 32'h10000000+i, target=32'h10000008 -> match_count=8, found=1, best_nonce=0, best_value=32'h10000000; mem[result_addr+1]=32'h80080000.
- All words FFFFFFFF, target=32'h00000100 -> found=0, match_count=0, best_value=FFFFFFFF, best_nonce=0; summary word 32'h00000000.
- Word 5=word 9=32'h00000042, others larger, target=32'h00000042 -> best_nonce=5 (tie keeps lower index), match_count=0 (strict compare), summary 32'h00000005.
- start at cycle 0 -> done low from edge 1 to edge 20, exactly one mem_we pulse of 2 cycles at edges 19-20; start pulses during the scan have no effect.
- input_addr=16'hFFFE -> reads from FFFE, FFFF, 0000..000D; results are correct.
- reset_n asserted at edge 10 -> mem_we=0 and done=1 immediately; memory at result_addr is untouched; a new start afterwards completes normally.
